// File: rtl/rr_dec_arbiter.sv
// Four-way round-robin arbiter with grant hold, bounded hold time and a dead cycle between owners.
// The owner is kept as a 2-bit index and decoded to a one-hot grant vector.
module rr_dec_arbiter #(
  parameter int unsigned MAX_HOLD = 8,
  parameter int unsigned HOLD_W   = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic [3:0] req,
  output logic [3:0] grant,
  output logic [1:0] gnt_idx,
  output logic       gnt_valid,
  output logic       preempt
);

  typedef enum logic [0:0] {StIdle, StBusy} state_e;

  localparam logic [HOLD_W-1:0] HoldLast = HOLD_W'(MAX_HOLD - 1);

  state_e            state_q, state_d;
  logic [1:0]        idx_q, idx_d;
  logic [1:0]        ptr_q, ptr_d;
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic              preempt_q, preempt_d;

  logic [1:0] winner;
  logic [1:0] cand;
  logic       found;
  logic [3:0] owner_mask;

  // Search begins just past the last winner and covers the whole ring,
  // so a lone requester can re-win after its own release.
  always_comb begin
    winner = ptr_q;
    cand   = '0;
    found  = 1'b0;
    for (int unsigned i = 1; i <= 4; i++) begin
      cand = ptr_q + 2'(i);
      if (!found && req[cand]) begin
        winner = cand;
        found  = 1'b1;
      end
    end
  end

  assign owner_mask = 4'b0001 << idx_q;

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    ptr_d     = ptr_q;
    hold_d    = hold_q;
    preempt_d = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (en && (req != 4'b0000)) begin
          state_d = StBusy;
          idx_d   = winner;
          ptr_d   = winner;
          hold_d  = '0;
        end
      end
      StBusy: begin
        if (!en || !req[idx_q]) begin
          state_d = StIdle;
        end else if ((hold_q == HoldLast) && ((req & ~owner_mask) != 4'b0000)) begin
          state_d   = StIdle;
          preempt_d = 1'b1;
        end else if (hold_q != HoldLast) begin
          hold_d = hold_q + 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      idx_q     <= 2'd0;
      ptr_q     <= 2'd3;
      hold_q    <= '0;
      preempt_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      ptr_q     <= ptr_d;
      hold_q    <= hold_d;
      preempt_q <= preempt_d;
    end
  end

  // Decoder enable is the registered valid, so grant is zero whenever no owner is held.
  assign gnt_valid = (state_q == StBusy);
  assign gnt_idx   = idx_q;
  assign grant     = gnt_valid ? owner_mask : 4'b0000;
  assign preempt   = preempt_q;

endmodule

// File: tb/tb_rr_dec_arbiter.sv
// Directed bench for rr_dec_arbiter: a round-robin vector table plus hand sequences
// for reset, preemption, uncontested hold, enable gating and same-cycle events.
module tb_rr_dec_arbiter;

  logic       clk;
  logic       rst_n;
  logic       en;
  logic [3:0] req;
  logic [3:0] grant;
  logic [1:0] gnt_idx;
  logic       gnt_valid;
  logic       preempt;

  int n_vec;
  int n_miss;

  typedef struct {
    logic       en;
    logic [3:0] req;
    logic [3:0] exp_grant;
    logic [1:0] exp_idx;
    logic       exp_valid;
    logic       exp_preempt;
  } vec_t;

  vec_t vecs[13];

  rr_dec_arbiter #(
    .MAX_HOLD(8),
    .HOLD_W  (4)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (en),
    .req      (req),
    .grant    (grant),
    .gnt_idx  (gnt_idx),
    .gnt_valid(gnt_valid),
    .preempt  (preempt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [3:0] eg, input logic [1:0] ei,
                       input logic ev, input logic ep);
    n_vec++;
    if ({grant, gnt_idx, gnt_valid, preempt} !== {eg, ei, ev, ep}) begin
      n_miss++;
      $display("FAIL %s: got grant=%b idx=%0d valid=%b preempt=%b, want grant=%b idx=%0d valid=%b preempt=%b",
               name, grant, gnt_idx, gnt_valid, preempt, eg, ei, ev, ep);
    end
  endtask

  // Called just after a rising edge; reset pulse completes before the next edge.
  task automatic do_reset(input logic [3:0] r);
    en    = 1'b1;
    req   = r;
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
  endtask

  initial begin
    n_vec  = 0;
    n_miss = 0;
    en     = 1'b1;
    req    = 4'b1111;
    rst_n  = 1'b0;

    // Round robin: each master drops its request after two grant cycles
    vecs[0]  = '{1'b1, 4'b1111, 4'b0001, 2'd0, 1'b1, 1'b0};
    vecs[1]  = '{1'b1, 4'b1111, 4'b0001, 2'd0, 1'b1, 1'b0};
    vecs[2]  = '{1'b1, 4'b1110, 4'b0000, 2'd0, 1'b0, 1'b0};
    vecs[3]  = '{1'b1, 4'b1110, 4'b0010, 2'd1, 1'b1, 1'b0};
    vecs[4]  = '{1'b1, 4'b1110, 4'b0010, 2'd1, 1'b1, 1'b0};
    vecs[5]  = '{1'b1, 4'b1100, 4'b0000, 2'd1, 1'b0, 1'b0};
    vecs[6]  = '{1'b1, 4'b1100, 4'b0100, 2'd2, 1'b1, 1'b0};
    vecs[7]  = '{1'b1, 4'b1100, 4'b0100, 2'd2, 1'b1, 1'b0};
    vecs[8]  = '{1'b1, 4'b1000, 4'b0000, 2'd2, 1'b0, 1'b0};
    vecs[9]  = '{1'b1, 4'b1000, 4'b1000, 2'd3, 1'b1, 1'b0};
    vecs[10] = '{1'b1, 4'b1000, 4'b1000, 2'd3, 1'b1, 1'b0};
    vecs[11] = '{1'b1, 4'b0111, 4'b0000, 2'd3, 1'b0, 1'b0};
    vecs[12] = '{1'b1, 4'b0111, 4'b0001, 2'd0, 1'b1, 1'b0};

    // Reset held with all requests pending
    step();
    step();
    check("reset_hold", 4'b0000, 2'd0, 1'b0, 1'b0);
    req   = 4'b0100;
    rst_n = 1'b1;
    step();
    check("first_grant", 4'b0100, 2'd2, 1'b1, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_reset", 4'b0000, 2'd0, 1'b0, 1'b0);
    step();

    // Round-robin table
    do_reset(4'b0000);
    for (int i = 0; i < 13; i++) begin
      en  = vecs[i].en;
      req = vecs[i].req;
      step();
      check($sformatf("rr_vec%0d", i), vecs[i].exp_grant, vecs[i].exp_idx,
            vecs[i].exp_valid, vecs[i].exp_preempt);
    end

    // Preemption: two contenders alternate, eight grant cycles then a dead cycle
    step();
    do_reset(4'b0011);
    for (int r = 0; r < 4; r++) begin
      logic [1:0] o;
      logic [3:0] m;
      o = (r % 2 == 0) ? 2'd0 : 2'd1;
      m = (r % 2 == 0) ? 4'b0001 : 4'b0010;
      for (int c = 0; c < 8; c++) begin
        step();
        check($sformatf("preempt_r%0d_c%0d", r, c), m, o, 1'b1, 1'b0);
      end
      step();
      check($sformatf("preempt_r%0d_dead", r), 4'b0000, o, 1'b0, 1'b1);
    end

    // Uncontested hold for 50 cycles, then release
    do_reset(4'b1000);
    for (int c = 0; c < 50; c++) begin
      step();
      check($sformatf("uncontested_c%0d", c), 4'b1000, 2'd3, 1'b1, 1'b0);
    end
    req = 4'b0000;
    step();
    check("uncontested_release", 4'b0000, 2'd3, 1'b0, 1'b0);

    // Enable gating keeps the pointer
    do_reset(4'b0100);
    step();
    check("gate_grant", 4'b0100, 2'd2, 1'b1, 1'b0);
    en = 1'b0;
    step();
    check("gate_drop", 4'b0000, 2'd2, 1'b0, 1'b0);
    req = 4'b1111;
    for (int c = 0; c < 5; c++) begin
      step();
      check($sformatf("gate_blocked_c%0d", c), 4'b0000, 2'd2, 1'b0, 1'b0);
    end
    en = 1'b1;
    step();
    check("gate_restore", 4'b1000, 2'd3, 1'b1, 1'b0);

    // Owner releases exactly at the hold limit while another master waits
    do_reset(4'b0011);
    for (int c = 0; c < 8; c++) step();
    check("same_cycle_pre", 4'b0001, 2'd0, 1'b1, 1'b0);
    req = 4'b0010;
    step();
    check("same_cycle_release", 4'b0000, 2'd0, 1'b0, 1'b0);
    step();
    check("same_cycle_next", 4'b0010, 2'd1, 1'b1, 1'b0);

    // Enable falls together with the hold limit: no preempt pulse
    do_reset(4'b0011);
    for (int c = 0; c < 8; c++) step();
    en = 1'b0;
    step();
    check("en_limit_drop", 4'b0000, 2'd0, 1'b0, 1'b0);
    step();
    check("en_limit_idle", 4'b0000, 2'd0, 1'b0, 1'b0);
    en = 1'b1;
    step();
    check("en_limit_next", 4'b0010, 2'd1, 1'b1, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
